// File: rtl/video_cap_capture_sched.sv
// video_cap_capture_sched: start/stop capture sequencer for the C2H bridge with frame watchdog and overflow recovery.
// Optional VIDEO_CAP_AUTO_RECOVER_EN: overflow in ARM/RUN soft-resets the bridge and re-arms up to MAX_RETRY times.
module video_cap_capture_sched #(
  parameter int SOFT_RST_CYCLES = 16,
  parameter int FRAME_CNT_W = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  input  logic                   cmd_start,
  input  logic                   cmd_stop,
  input  logic [FRAME_CNT_W-1:0] cfg_frame_count,
  input  logic [31:0]            cfg_timeout_cycles,
  input  logic                   frame_done,
  input  logic                   bridge_overflow,
  output logic                   ctrl_enable,
  output logic                   ctrl_soft_reset,
  output logic                   sts_busy,
  output logic [2:0]             sts_state,
  output logic [FRAME_CNT_W-1:0] sts_frame_cnt,
  output logic [3:0]             sts_retry_cnt,
  output logic                   sts_err_timeout,
  output logic                   sts_err_overflow,
  output logic                   done_pulse
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, FLUSH = 3'd1, ARM = 3'd2, RUN = 3'd3, DRAIN = 3'd4, RECOVER = 3'd5, FAULT = 3'd6
  } state_t;

  state_t state, state_n;
  logic [FRAME_CNT_W-1:0] frame_n, n_q, n_q_n;
  logic [31:0] to_q, to_q_n, wd, wd_n;
  logic [15:0] sr, sr_n;
  logic [3:0] retry_n;
  logic err_to_n, err_ov_n, done_n, active, hit, expire;

  assign active = state == ARM || state == RUN || state == DRAIN;
  assign hit = active && frame_done && n_q != '0 && sts_frame_cnt == n_q - FRAME_CNT_W'(1);
  // The watchdog expires on the cycle its count would reach the limit, unless a frame lands then.
  assign expire = active && !frame_done && to_q != '0 && wd == to_q - 32'd1;
  assign sts_state = state;

  always_comb begin
    state_n = state;
    frame_n = sts_frame_cnt;
    retry_n = sts_retry_cnt;
    err_to_n = sts_err_timeout;
    err_ov_n = sts_err_overflow;
    n_q_n = n_q;
    to_q_n = to_q;
    sr_n = '0;
    wd_n = '0;
    done_n = 1'b0;
    case (state)
      IDLE, FAULT: begin
        if (cmd_stop) state_n = IDLE;
        else if (cmd_start) begin
          n_q_n = cfg_frame_count;
          to_q_n = cfg_timeout_cycles;
          frame_n = '0;
          retry_n = '0;
          err_to_n = 1'b0;
          err_ov_n = 1'b0;
          state_n = FLUSH;
        end
      end
      FLUSH, RECOVER: begin
        sr_n = sr + 16'd1;
        if (cmd_stop) state_n = IDLE;
        else if (sr == 16'(SOFT_RST_CYCLES - 1)) state_n = ARM;
      end
      ARM, RUN, DRAIN: begin
        wd_n = frame_done ? '0 : wd + 32'd1;
        if (frame_done) frame_n = sts_frame_cnt + FRAME_CNT_W'(1);
        if (hit) begin
          done_n = 1'b1;
          state_n = IDLE;
        end else if (bridge_overflow) begin
          if (state == DRAIN) begin
            err_ov_n = 1'b1;
            state_n = IDLE;
          end else begin
`ifdef VIDEO_CAP_AUTO_RECOVER_EN
            if (sts_retry_cnt < 4'(MAX_RETRY)) begin
              retry_n = sts_retry_cnt + 4'd1;
              state_n = RECOVER;
            end else begin
              err_ov_n = 1'b1;
              state_n = FAULT;
            end
`else
            err_ov_n = 1'b1;
            state_n = FAULT;
`endif
          end
        end else if (cmd_stop) state_n = state == RUN ? DRAIN : IDLE;
        else if (frame_done) state_n = state == DRAIN ? IDLE : RUN;
        else if (expire) begin
          err_to_n = 1'b1;
          state_n = state == DRAIN ? IDLE : FAULT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state <= IDLE;
      sts_frame_cnt <= '0;
      sts_retry_cnt <= '0;
      sts_err_timeout <= 1'b0;
      sts_err_overflow <= 1'b0;
      done_pulse <= 1'b0;
      ctrl_enable <= 1'b0;
      ctrl_soft_reset <= 1'b0;
      sts_busy <= 1'b0;
      n_q <= '0;
      to_q <= '0;
      wd <= '0;
      sr <= '0;
    end else begin
      state <= state_n;
      sts_frame_cnt <= frame_n;
      sts_retry_cnt <= retry_n;
      sts_err_timeout <= err_to_n;
      sts_err_overflow <= err_ov_n;
      done_pulse <= done_n;
      ctrl_enable <= state_n == ARM || state_n == RUN || state_n == DRAIN;
      ctrl_soft_reset <= state_n == FLUSH || state_n == RECOVER;
      sts_busy <= state_n != IDLE && state_n != FAULT;
      n_q <= n_q_n;
      to_q <= to_q_n;
      wd <= wd_n;
      sr <= sr_n;
    end
  end
endmodule
